// File: rtl/loop_stack_if.sv
// ============================================================================
// Module   : loop_stack_if
// Purpose  : Command/status bundle between the control unit and loop_stack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface loop_stack_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
);
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] top;
   logic [DEPTH:0]   count;
   logic             empty;
   logic             full;
   logic             err;

   modport master (
      output push, pop, wd,
      input  top, count, empty, full, err
   );

   modport slave (
      input  push, pop, wd,
      output top, count, empty, full, err
   );
endinterface

`default_nettype wire

// File: rtl/loop_stack.sv
// ============================================================================
// Module   : loop_stack
// Purpose  : Self-managing LIFO of loop-start PCs with push/pop/replace.
//            Optional sticky error flag enabled by macro LOOP_STACK_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module loop_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  wire          clk,
   input  wire          reset,
   loop_stack_if.slave  bus
);
   localparam int             c_ENTRIES = 2 ** DEPTH;
   localparam logic [DEPTH:0] c_ONE     = {{DEPTH{1'b0}}, 1'b1};
   localparam logic [DEPTH:0] c_CAP     = {1'b1, {DEPTH{1'b0}}};

   logic [DEPTH:0]       sp_q;
   logic [DEPTH:0]       sp_d;
   logic [DEPTH:0]       w_sp_m1;
   logic [WIDTH-1:0]     store_q [0:c_ENTRIES-1];
   logic                 w_we;
   logic [DEPTH-1:0]     w_waddr;
   logic                 w_empty;
   logic                 w_full;

   assign w_empty = (sp_q == '0);
   assign w_full  = (sp_q == c_CAP);
   assign w_sp_m1 = sp_q - c_ONE;

   always_comb begin
      sp_d    = sp_q;
      w_we    = 1'b0;
      w_waddr = sp_q[DEPTH-1:0];
      unique case ({bus.push, bus.pop})
         2'b10: begin
            if (!w_full) begin
               w_we = 1'b1;
               sp_d = sp_q + c_ONE;
            end
         end
         2'b01: begin
            if (!w_empty) begin
               sp_d = w_sp_m1;
            end
         end
         2'b11: begin
            // Replace on a non-empty stack; on an empty one it degrades to a push at 0.
            w_we = 1'b1;
            if (!w_empty) begin
               w_waddr = w_sp_m1[DEPTH-1:0];
            end else begin
               w_waddr = '0;
               sp_d    = c_ONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we && !reset) begin
         store_q[w_waddr] <= bus.wd;
      end
   end

   assign bus.top   = w_empty ? '0 : store_q[w_sp_m1[DEPTH-1:0]];
   assign bus.count = sp_q;
   assign bus.empty = w_empty;
   assign bus.full  = w_full;

`ifdef LOOP_STACK_ERR_EN
   logic err_q;
   logic w_illegal;

   assign w_illegal = (bus.push && !bus.pop && w_full) ||
                      (!bus.push && bus.pop && w_empty);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (w_illegal) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_loop_stack.sv
// ============================================================================
// Module   : tb_loop_stack
// Purpose  : Directed vector bench for loop_stack (DEPTH=2, WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loop_stack;
   localparam int DEPTH = 2;
   localparam int WIDTH = 16;
`ifdef LOOP_STACK_ERR_EN
   localparam bit c_ERR_ON = 1'b1;
`else
   localparam bit c_ERR_ON = 1'b0;
`endif

   typedef struct {
      bit          rst;
      bit          push;
      bit          pop;
      logic [15:0] wd;
      logic [15:0] top;
      int          count;
      bit          empty;
      bit          full;
      bit          err;   // value expected when the error flag is built
   } vec_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   vec_t vecs[$];

   loop_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   loop_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input bit r, input bit pu, input bit po, input logic [15:0] wd,
                      input logic [15:0] top, input int cnt, input bit e, input bit f, input bit er);
      vec_t v;
      v.rst = r; v.push = pu; v.pop = po; v.wd = wd;
      v.top = top; v.count = cnt; v.empty = e; v.full = f; v.err = er;
      vecs.push_back(v);
   endtask

   task automatic step_check(input int idx, input vec_t v);
      @(negedge clk);
      reset    = v.rst;
      bus.push = v.push;
      bus.pop  = v.pop;
      bus.wd   = v.wd;
      @(posedge clk);
      #1;
      check("top",   idx, 32'(bus.top),   32'(v.top));
      check("count", idx, 32'(bus.count), 32'(v.count));
      check("empty", idx, 32'(bus.empty), 32'(v.empty));
      check("full",  idx, 32'(bus.full),  32'(v.full));
      check("err",   idx, 32'(bus.err),   32'(v.err & c_ERR_ON));
   endtask

   initial begin
      vec_t v;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.wd   = '0;

      //   rst push pop wd       top      cnt e  f  err
      add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
      add(0, 1, 0, 16'h0010, 16'h0010, 1, 0, 0, 0);
      add(0, 1, 0, 16'h0020, 16'h0020, 2, 0, 0, 0);
      add(0, 1, 0, 16'h0030, 16'h0030, 3, 0, 0, 0);
      add(0, 1, 0, 16'h0040, 16'h0040, 4, 0, 1, 0);
      add(0, 1, 0, 16'h0050, 16'h0040, 4, 0, 1, 1);
      add(0, 0, 1, 16'h0000, 16'h0030, 3, 0, 0, 1);
      add(0, 0, 1, 16'h0000, 16'h0020, 2, 0, 0, 1);
      add(0, 0, 1, 16'h0000, 16'h0010, 1, 0, 0, 1);
      add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 1);
      add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 1);
      add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
      add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 1);
      add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
      add(0, 1, 0, 16'h0100, 16'h0100, 1, 0, 0, 0);
      add(0, 0, 0, 16'h0999, 16'h0100, 1, 0, 0, 0);
      add(0, 1, 1, 16'h0200, 16'h0200, 1, 0, 0, 0);
      add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0);
      add(0, 1, 1, 16'h0300, 16'h0300, 1, 0, 0, 0);
      add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0);
      add(0, 1, 0, 16'h0001, 16'h0001, 1, 0, 0, 0);
      add(0, 1, 0, 16'h0002, 16'h0002, 2, 0, 0, 0);
      add(0, 1, 0, 16'h0003, 16'h0003, 3, 0, 0, 0);
      add(0, 1, 0, 16'h0004, 16'h0004, 4, 0, 1, 0);
      add(0, 1, 1, 16'h00AA, 16'h00AA, 4, 0, 1, 0);
      add(0, 0, 1, 16'h0000, 16'h0003, 3, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step_check(i, vecs[i]);
      end

      // Reset together with a push: the push is discarded and the stack empties.
      v.rst = 1; v.push = 1; v.pop = 0; v.wd = 16'h0777;
      v.top = 16'h0000; v.count = 0; v.empty = 1; v.full = 0; v.err = 0;
      step_check(100, v);
      v.rst = 0; v.push = 1; v.pop = 0; v.wd = 16'h0001;
      v.top = 16'h0001; v.count = 1; v.empty = 0; v.full = 0; v.err = 0;
      step_check(101, v);

      // Push then pop back-to-back: pushed value visible between the edges.
      v.rst = 0; v.push = 1; v.pop = 0; v.wd = 16'hBEEF;
      v.top = 16'hBEEF; v.count = 2; v.empty = 0; v.full = 0; v.err = 0;
      step_check(102, v);
      v.rst = 0; v.push = 0; v.pop = 1; v.wd = 16'h0000;
      v.top = 16'h0001; v.count = 1; v.empty = 0; v.full = 0; v.err = 0;
      step_check(103, v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout total=%0d", total);
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire

// File: doc/loop_stack.md
# loop_stack

Self-managing LIFO for the brainfuck machine's loop-address tracking, replacing externally addressed stack RAM. It keeps its own stack pointer and presents push/pop/replace operations, top-of-stack read, occupancy, full/empty flags and an optional sticky error flag. The control unit pushes the loop-start PC on `[` and pops or re-reads it on `]`, with no pointer bookkeeping of its own.

## Interface
- `DEPTH`, default 4: address bits; capacity is 2**DEPTH entries.
- `WIDTH`, default 16: entry width in bits (PC width).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  push `wd` (or replace the top entry when `pop` is also high).
- `pop`  in  1  remove the top entry.
- `wd`  in  WIDTH  data to push or replace.
- `top`  out  WIDTH  current top entry; 0 when empty.
- `count`  out  DEPTH+1  number of valid entries, 0 to 2**DEPTH.
- `empty`  out  1  high when `count` == 0.
- `full`  out  1  high when `count` == 2**DEPTH.
- `err`  out  1  sticky overflow/underflow flag (see Configuration).

## Operation
- Storage: 2**DEPTH x WIDTH array, not reset. Internal pointer `sp` equals `count`. Entry i lives at address i, and the top is at `sp-1`.
- Each edge with `reset` low resolves the command from {`push`,`pop`} as follows:
  - 00 idle: no change.
  - 10 push: if not full, write `wd` at `sp` and increment `sp`. If full, this is an overflow: array and `sp` are unchanged.
  - 01 pop: if not empty, decrement `sp`; the array is unchanged. If empty, this is an underflow: no change.
  - 11 replace: if not empty, write `wd` at `sp-1` and leave `sp` unchanged; legal when full. If empty, this behaves as a plain push: write at 0, `sp` becomes 1, no error.
- `top`:
  - Combinational: `store[sp-1]` when `sp` != 0, else 0.
  - Reflects a push, pop or replace from the cycle after the edge.
- `empty`, `full` and `count` are decoded directly from `sp`. Never both high when DEPTH ≥ 0.
- Pointer arithmetic is DEPTH+1 bits. The array is indexed with the low DEPTH bits. `sp` never exceeds 2**DEPTH and never wraps, because illegal operations are blocked.
- Illegal operations (overflow, underflow) never corrupt state, with or without the configuration macro.
- `reset` wins over any simultaneous `push`/`pop`. The command in the reset cycle is discarded.

## Timing
- After reset: `sp`=0, `count`=0, `empty`=1, `full`=0, `top`=0, `err`=0.
- Write/pointer latency: 1 cycle. The updated `top`/`count`/flags are valid right after the edge.
- Read latency: 0 cycles (combinational from `sp` and the array).
- Back-to-back operations are allowed every cycle with no bubbles. Push then pop on consecutive cycles returns the pushed value on `top` between the two edges.
- Reset mid-sequence:
  - Empties the stack in one cycle.
  - Old array contents remain but are unreachable. `top` shows 0 until the next push.

## Configuration
- Macro `LOOP_STACK_ERR_EN`.
- Defined: `err` is a register.
  - It is set on the edge of any overflow (push alone when full) or underflow (pop alone when empty).
  - It stays set until `reset`. Setting it does not block further legal operations.
- Undefined: `err` is tied to 0 and no error register is built. Illegal operations are still ignored as described in Operation.

## Test plan
- Reset/fill (DEPTH=2, WIDTH=16): reset, then push 0x0010, 0x0020, 0x0030, 0x0040 on consecutive cycles -> `count` 1,2,3,4; `top` 0x0040; `full`=1, `empty`=0; `err`=0.
- Overflow: from full, push 0x0050 -> `count` stays 4 and `top` stays 0x0040. `err`=1 with `LOOP_STACK_ERR_EN`, 0 without. Then pop -> `top`=0x0030, `count`=3, `err` still 1.
- Drain/underflow:
  - Pop four times -> `top` 0x0030, 0x0020, 0x0010, then 0; `empty`=1.
  - A fifth pop -> `count` stays 0; `err` set (macro on).
- Replace:
  - Push 0x0100, then push+pop with `wd`=0x0200 -> `count`=1, `top`=0x0200.
  - Push+pop on an empty stack with `wd`=0x0300 -> `count`=1, `top`=0x0300, `err` unchanged.
- Replace at full: fill with 0x1..0x4, then push+pop with `wd`=0x00AA -> `count`=4, `top`=0x00AA, `err`=0. Pop -> `top`=0x0003.
- Reset priority: with 3 entries, assert `reset` together with `push` 0x0777 -> next cycle `count`=0, `top`=0, `err`=0. Then push 0x0001 -> `top`=0x0001, `count`=1.
